// File: rtl/peripheral_interco_pkg.sv
// Shared defaults for the peripheral interconnect response path,
// plus the pointer sizing helper used by the ID FIFO.
package peripheral_interco_pkg;

    localparam int unsigned DefIdWidth      = 20;
    localparam int unsigned DefDataWidth    = 32;
    localparam int unsigned DefNOutstanding = 4;

    // One extra bit beyond the address lets full and empty be told apart.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/id_fifo_pe.sv
// ID FIFO holding the master IDs of outstanding requests, oldest first.
module id_fifo_pe
    import peripheral_interco_pkg::*;
#(
    parameter int unsigned WIDTH = DefIdWidth,
    parameter int unsigned DEPTH = DefNOutstanding
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW  = ptr_width(DEPTH);
    localparam int unsigned AddrW = PtrW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;

    // Callers are expected to gate push/pop with full/empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

endmodule

// File: rtl/resp_id_tracker_pe.sv
// Tracks master IDs of granted requests and tags peripheral responses
// with them, one cycle after the response arrives.
module resp_id_tracker_pe
    import peripheral_interco_pkg::*;
#(
    parameter int unsigned ID_WIDTH      = DefIdWidth,
    parameter int unsigned DATA_WIDTH    = DefDataWidth,
    parameter int unsigned N_OUTSTANDING = DefNOutstanding
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [ID_WIDTH-1:0]   ID_i,
    input  logic                  gnt_i,
    output logic                  req_o,
    output logic                  gnt_o,
    input  logic                  r_valid_i,
    input  logic [DATA_WIDTH-1:0] r_rdata_i,
    output logic                  data_r_valid_o,
    output logic [ID_WIDTH-1:0]   data_ID_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                  err_o
);

    logic                  full, empty, push, pop;
    logic [ID_WIDTH-1:0]   fifo_rdata;

    logic                  valid_q, valid_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    assign req_o = req_i & ~full;
    assign gnt_o = gnt_i & req_i & ~full;
    assign push  = req_i & gnt_i & ~full;
    // No bypass: a response into an empty FIFO is spurious even if a push lands now.
    assign pop   = r_valid_i & ~empty;

    id_fifo_pe #(
        .WIDTH (ID_WIDTH),
        .DEPTH (N_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (ID_i),
        .rdata_o (fifo_rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        valid_d = pop;
        id_d    = pop ? fifo_rdata : '0;
        rdata_d = pop ? r_rdata_i : rdata_q;
        err_d   = err_q | (r_valid_i & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign data_r_valid_o = valid_q;
    assign data_ID_o      = id_q;
    assign data_r_rdata_o = rdata_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_resp_id_tracker_pe.sv
// Directed bench for resp_id_tracker_pe with default parameters.
module tb_resp_id_tracker_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, gnt_i, r_valid_i;
    logic [19:0] ID_i;
    logic [31:0] r_rdata_i;
    logic        req_o, gnt_o, data_r_valid_o, err_o;
    logic [19:0] data_ID_o;
    logic [31:0] data_r_rdata_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    resp_id_tracker_pe dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .ID_i           (ID_i),
        .gnt_i          (gnt_i),
        .req_o          (req_o),
        .gnt_o          (gnt_o),
        .r_valid_i      (r_valid_i),
        .r_rdata_i      (r_rdata_i),
        .data_r_valid_o (data_r_valid_o),
        .data_ID_o      (data_ID_o),
        .data_r_rdata_o (data_r_rdata_o),
        .err_o          (err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_id(input logic [19:0] id);
        req_i = 1'b1;
        gnt_i = 1'b1;
        ID_i  = id;
        tick();
        req_i = 1'b0;
        gnt_i = 1'b0;
        ID_i  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_i = 1'b0; gnt_i = 1'b0; r_valid_i = 1'b0;
        ID_i = '0; r_rdata_i = '0;
        tick();
        req_i = 1'b1; gnt_i = 1'b1;
        #1;
        chk("rst_req_o", req_o, 1);
        chk("rst_gnt_o", gnt_o, 1);
        req_i = 1'b0; gnt_i = 1'b0;
        tick();
        chk("rst_valid", data_r_valid_o, 0);
        chk("rst_id", data_ID_o, 0);
        chk("rst_rdata", data_r_rdata_o, 0);
        chk("rst_err", err_o, 0);
        rst = 1'b0;

        // Single transaction
        req_i = 1'b1; gnt_i = 1'b1; ID_i = 20'h00004;
        #1;
        chk("t1_gnt_o", gnt_o, 1);
        chk("t1_req_o", req_o, 1);
        tick();
        req_i = 1'b0; gnt_i = 1'b0; ID_i = '0;
        tick();
        chk("t1_idle_valid", data_r_valid_o, 0);
        tick();
        r_valid_i = 1'b1; r_rdata_i = 32'hDEADBEEF;
        tick();
        r_valid_i = 1'b0; r_rdata_i = 32'h0;
        chk("t1_valid", data_r_valid_o, 1);
        chk("t1_id", data_ID_o, 20'h00004);
        chk("t1_rdata", data_r_rdata_o, 32'hDEADBEEF);
        tick();
        chk("t1_after_valid", data_r_valid_o, 0);
        chk("t1_after_id", data_ID_o, 0);
        chk("t1_after_rdata_hold", data_r_rdata_o, 32'hDEADBEEF);
        chk("t1_err", err_o, 0);

        // Ordering
        for (int i = 0; i < 4; i++) push_id(20'(1 << i));
        for (int i = 0; i < 4; i++) begin
            r_valid_i = 1'b1; r_rdata_i = 32'hA0 + 32'(i);
            tick();
            chk("ord_valid", data_r_valid_o, 1);
            chk("ord_id", data_ID_o, 64'(1 << i));
            chk("ord_rdata", data_r_rdata_o, 64'(32'hA0 + 32'(i)));
        end
        r_valid_i = 1'b0;
        tick();
        chk("ord_end_valid", data_r_valid_o, 0);

        // Full: push blocked even with a same-cycle pop
        for (int i = 0; i < 4; i++) push_id(20'(1 << i));
        req_i = 1'b1; gnt_i = 1'b1; ID_i = 20'h00010;
        r_valid_i = 1'b1; r_rdata_i = 32'h55;
        #1;
        chk("full_req_o", req_o, 0);
        chk("full_gnt_o", gnt_o, 0);
        tick();
        r_valid_i = 1'b0;
        chk("full_pop_id", data_ID_o, 20'h00001);
        chk("full_next_gnt_o", gnt_o, 1);
        chk("full_next_req_o", req_o, 1);
        req_i = 1'b0; gnt_i = 1'b0; ID_i = '0;
        for (int i = 1; i < 4; i++) begin
            r_valid_i = 1'b1;
            tick();
            chk("full_drain_valid", data_r_valid_o, 1);
            chk("full_drain_id", data_ID_o, 64'(1 << i));
        end
        r_valid_i = 1'b0;
        tick();
        chk("full_drain_err", err_o, 0);

        // Pointer wrap with IDs spanning bit 0 to bit 19
        for (int i = 0; i < 10; i++) begin
            push_id(20'(1 << ((i * 19) / 9)));
            r_valid_i = 1'b1; r_rdata_i = 32'h1000 + 32'(i);
            tick();
            r_valid_i = 1'b0;
            chk("wrap_valid", data_r_valid_o, 1);
            chk("wrap_id", data_ID_o, 64'(1 << ((i * 19) / 9)));
            chk("wrap_rdata", data_r_rdata_o, 64'(32'h1000 + 32'(i)));
        end
        chk("wrap_err", err_o, 0);

        // Non-one-hot ID stored as is
        push_id(20'h00005);
        r_valid_i = 1'b1; r_rdata_i = 32'h77;
        tick();
        r_valid_i = 1'b0;
        chk("nonhot_id", data_ID_o, 20'h00005);

        // Spurious response with empty FIFO
        r_valid_i = 1'b1; r_rdata_i = 32'h99;
        tick();
        r_valid_i = 1'b0;
        chk("spur_valid", data_r_valid_o, 0);
        chk("spur_err", err_o, 1);
        chk("spur_rdata_hold", data_r_rdata_o, 32'h77);
        tick(); tick();
        chk("spur_err_held", err_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("spur_err_cleared", err_o, 0);

        // Reset mid-flight discards stored IDs
        push_id(20'h00002);
        push_id(20'h00008);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r_valid_i = 1'b1; r_rdata_i = 32'h1234;
        tick();
        r_valid_i = 1'b0;
        chk("mid_valid", data_r_valid_o, 0);
        chk("mid_id", data_ID_o, 0);
        chk("mid_err", err_o, 1);
        tick();
        chk("mid_valid2", data_r_valid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/resp_id_tracker_pe.md
RESP_ID_TRACKER_PE -- requirements
Module: resp_id_tracker_pe

Interface
REQ-001 Parameter ID_WIDTH, default 20, one-hot master ID width; this is the response-decoder N_MASTER.
REQ-002 Parameter DATA_WIDTH, default 32, response data width.
REQ-003 Parameter N_OUTSTANDING, default 4, ID FIFO depth; power of 2, >=2.
REQ-004 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port req_i, input, 1, arbitrated request toward the peripheral.
REQ-007 Port ID_i, input, ID_WIDTH, one-hot ID of the requesting master.
REQ-008 Port gnt_i, input, 1, grant from the peripheral.
REQ-009 Port req_o, output, 1, request forwarded to the peripheral, masked when full.
REQ-010 Port gnt_o, output, 1, grant returned to the arbiter, masked when full.
REQ-011 Port r_valid_i, input, 1, response valid from the peripheral.
REQ-012 Port r_rdata_i, input, DATA_WIDTH, response data from the peripheral.
REQ-013 Port data_r_valid_o, output, 1, registered response valid to the response address decoder.
REQ-014 Port data_ID_o, output, ID_WIDTH, registered one-hot ID to the response address decoder.
REQ-015 Port data_r_rdata_o, output, DATA_WIDTH, registered response data.
REQ-016 Port err_o, output, 1, sticky protocol-error flag.

Function
REQ-017 req_o SHALL equal req_i & ~full; gnt_o SHALL equal gnt_i & req_i & ~full (combinational).
REQ-018 A push SHALL occur when req_i & gnt_i & ~full, writing ID_i at the write pointer.
REQ-019 A pop SHALL occur when r_valid_i & ~empty, reading the entry at the read pointer.
REQ-020 Pointers SHALL be log2(N_OUTSTANDING)+1 bits and wrap modulo 2*N_OUTSTANDING.
- full: MSBs differ and the remaining bits are equal.
- empty: pointers are equal.
REQ-021 Occupancy SHALL go +1 on push only, -1 on pop only, and stay unchanged on simultaneous push and pop.
REQ-022 When full, push SHALL be blocked even if a pop occurs in the same cycle; no same-cycle slot reuse.
REQ-023 When empty, a push and r_valid_i in the same cycle SHALL NOT bypass; the response is treated as spurious.
REQ-024 Response latency SHALL be exactly 1 cycle.
- Pop at cycle N -> data_r_valid_o=1, data_ID_o=popped ID, data_r_rdata_o=r_rdata_i at N+1.
REQ-025 data_r_valid_o SHALL be 0 in any cycle following a cycle with no pop.
- data_ID_o SHALL be all-zero then.
- data_r_rdata_o SHALL hold its last value.
REQ-026 r_valid_i while empty SHALL set err_o.
- No pop, no output valid.
- err_o stays 1 until reset.
REQ-027 A pushed ID that is not one-hot SHALL be stored unchanged; the block does not check or correct IDs.

Reset
REQ-028 With rst=1 at a clock edge, the following SHALL be cleared to 0:
- both pointers, so the FIFO is empty;
- data_r_valid_o, data_ID_o, data_r_rdata_o;
- err_o.
REQ-029 Reset during outstanding transactions SHALL discard all stored IDs.
- Responses arriving after reset are spurious per REQ-026.
REQ-030 While rst=1, req_o and gnt_o SHALL follow REQ-017 using the reset-state full=0.

Structure
REQ-031 ID FIFO storage and pointer logic SHALL be one sub-module, id_fifo_pe.
- Parameters: width ID_WIDTH, depth N_OUTSTANDING.
- Ports: push, pop, wdata, rdata, full, empty.
REQ-032 The shared package peripheral_interco_pkg SHALL hold:
- the default ID_WIDTH, DATA_WIDTH and N_OUTSTANDING constants;
- the pointer-width function.
No other typedefs are required.

Verification
REQ-033 Single transaction: push ID=0x00004 at cycle 0, r_valid_i with rdata=0xDEADBEEF at cycle 3.
- Cycle 4: data_r_valid_o=1, data_ID_o=0x00004, data_r_rdata_o=0xDEADBEEF.
REQ-034 Ordering: push IDs 0x1, 0x2, 0x4, 0x8, then 4 back-to-back responses.
- Outputs carry IDs 0x1, 0x2, 0x4, 0x8 on consecutive cycles.
REQ-035 Full: 4 pushes, then req_i=1, gnt_i=1 with a simultaneous r_valid_i.
- gnt_o=0, req_o=0, occupancy 3 afterwards.
- Next cycle gnt_o=1.
REQ-036 Pointer wrap: 10 push/pop pairs with IDs cycling 0x1..0x80000.
- Every returned ID matches its push.
- No err_o.
REQ-037 Spurious response: r_valid_i with the FIFO empty.
- data_r_valid_o stays 0.
- err_o=1 next cycle and held.
- Cleared only by rst.
REQ-038 Reset mid-flight: 2 pushes, rst for 1 cycle, then r_valid_i.
- No output valid.
- err_o=1.
